// File: rtl/gpu_fb_scheduler.sv
// Frame-buffer write scheduler: arbitrates rasterizer draws, a full-screen
// clear engine and buffer-swap flushes onto a single SRAM write port.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_fb_scheduler #(
  parameter int unsigned WIDTH_BITS   = `WIDTH_BITS,
  parameter int unsigned HEIGHT_BITS  = `HEIGHT_BITS,
  parameter int unsigned CHANNEL_BITS = `CHANNEL_BITS,
  parameter int unsigned FRAME_W      = 640,
  parameter int unsigned FRAME_H      = 480
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      draw_valid,
  output logic                      draw_ready,
  input  logic [WIDTH_BITS-1:0]     draw_x,
  input  logic [HEIGHT_BITS-1:0]    draw_y,
  input  logic [3*CHANNEL_BITS-1:0] draw_rgb,
  input  logic                      clear_req,
  input  logic [3*CHANNEL_BITS-1:0] clear_rgb,
  input  logic                      swap_req,
  output logic                      data_ready_o,
  output logic [CHANNEL_BITS-1:0]   rdata,
  output logic [CHANNEL_BITS-1:0]   gdata,
  output logic [CHANNEL_BITS-1:0]   bdata,
  output logic [WIDTH_BITS-1:0]     adddatax,
  output logic [HEIGHT_BITS-1:0]    adddatay,
  output logic                      flush,
  output logic                      busy,
  output logic                      swap_done
);

  localparam int unsigned RGB_BITS = 3 * CHANNEL_BITS;
  localparam logic [WIDTH_BITS-1:0]  X_LAST = WIDTH_BITS'(FRAME_W - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_LAST = HEIGHT_BITS'(FRAME_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CLEAR = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t                   r_state,      w_state;
  logic                     r_clear_pend, w_clear_pend;
  logic                     r_swap_pend,  w_swap_pend;
  logic [RGB_BITS-1:0]      r_pend_rgb,   w_pend_rgb;
  logic [RGB_BITS-1:0]      r_clr_rgb,    w_clr_rgb;
  logic [WIDTH_BITS-1:0]    r_cx,         w_cx;
  logic [HEIGHT_BITS-1:0]   r_cy,         w_cy;
  logic                     r_wr,         w_wr;
  logic [WIDTH_BITS-1:0]    r_x,          w_x;
  logic [HEIGHT_BITS-1:0]   r_y,          w_y;
  logic [RGB_BITS-1:0]      r_rgb,        w_rgb;
  logic                     r_flush,      w_flush;
  logic                     r_swap_done,  w_swap_done;
  logic                     r_busy,       w_busy;
  logic                     w_draw_ready;

  // Draws are only taken when no clear or swap is queued ahead of them.
  assign w_draw_ready = ((r_state == S_IDLE) || (r_state == S_DRAW)) &&
                        !r_clear_pend && !r_swap_pend;

  // Next-state, pending-flag and output-register computation.
  always_comb begin
    w_state      = r_state;
    w_clear_pend = r_clear_pend | clear_req;
    w_swap_pend  = r_swap_pend | swap_req;
    w_pend_rgb   = clear_req ? clear_rgb : r_pend_rgb;
    w_clr_rgb    = r_clr_rgb;
    w_cx         = r_cx;
    w_cy         = r_cy;
    w_wr         = 1'b0;
    w_x          = r_x;
    w_y          = r_y;
    w_rgb        = r_rgb;
    w_flush      = 1'b0;
    w_swap_done  = r_flush;
    case (r_state)
      S_IDLE, S_DRAW: begin
        if (r_clear_pend) begin
          // A request arriving this same cycle re-arms the flag for a later clear.
          w_state      = S_CLEAR;
          w_clear_pend = clear_req;
          w_clr_rgb    = r_pend_rgb;
          w_cx         = '0;
          w_cy         = '0;
        end else if (r_swap_pend) begin
          w_state = S_SWAP;
        end else if (draw_valid && w_draw_ready) begin
          w_state = S_DRAW;
          w_wr    = 1'b1;
          w_x     = draw_x;
          w_y     = draw_y;
          w_rgb   = draw_rgb;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_wr  = 1'b1;
        w_x   = r_cx;
        w_y   = r_cy;
        w_rgb = r_clr_rgb;
        if (r_cx == X_LAST) begin
          w_cx = '0;
          if (r_cy == Y_LAST) begin
            w_cy    = '0;
            w_state = r_swap_pend ? S_SWAP : S_IDLE;
          end else begin
            w_cy = r_cy + HEIGHT_BITS'(1);
          end
        end else begin
          w_cx = r_cx + WIDTH_BITS'(1);
        end
      end
      S_SWAP: begin
        w_flush     = 1'b1;
        w_swap_pend = swap_req;
        w_state     = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE) || w_clear_pend || w_swap_pend;
  end

  // State, pending flags, counters and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_clear_pend <= 1'b0;
      r_swap_pend  <= 1'b0;
      r_pend_rgb   <= '0;
      r_clr_rgb    <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_wr         <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_rgb        <= '0;
      r_flush      <= 1'b0;
      r_swap_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_clear_pend <= w_clear_pend;
      r_swap_pend  <= w_swap_pend;
      r_pend_rgb   <= w_pend_rgb;
      r_clr_rgb    <= w_clr_rgb;
      r_cx         <= w_cx;
      r_cy         <= w_cy;
      r_wr         <= w_wr;
      r_x          <= w_x;
      r_y          <= w_y;
      r_rgb        <= w_rgb;
      r_flush      <= w_flush;
      r_swap_done  <= w_swap_done;
      r_busy       <= w_busy;
    end
  end

  assign draw_ready   = w_draw_ready;
  assign data_ready_o = r_wr;
  assign rdata        = r_rgb[RGB_BITS-1 -: CHANNEL_BITS];
  assign gdata        = r_rgb[2*CHANNEL_BITS-1 -: CHANNEL_BITS];
  assign bdata        = r_rgb[CHANNEL_BITS-1:0];
  assign adddatax     = r_x;
  assign adddatay     = r_y;
  assign flush        = r_flush;
  assign busy         = r_busy;
  assign swap_done    = r_swap_done;

endmodule

// File: doc/gpu_fb_scheduler.md
# gpu_fb_scheduler

Frame-buffer write scheduler that sits directly upstream of `gpu_memcontroller`. It shares the single SRAM write path among three sources: rasterizer pixel writes, a built-in full-screen clear engine and buffer-swap (flush) requests. It emits at most one pixel write per cycle. It sequences the flush so that no pixel write lands in the same cycle as a buffer toggle.

## Interface

Parameters:

- `WIDTH_BITS`, default `` `WIDTH_BITS `` (10): x coordinate width.
- `HEIGHT_BITS`, default `` `HEIGHT_BITS `` (9): y coordinate width.
- `CHANNEL_BITS`, default `` `CHANNEL_BITS `` (8): width of one colour channel.
- `FRAME_W`, default 640: pixels per row. Must satisfy 1 ≤ FRAME_W ≤ 2^WIDTH_BITS.
- `FRAME_H`, default 480: rows per frame. Must satisfy 1 ≤ FRAME_H ≤ 2^HEIGHT_BITS.

Ports (one clock; reset is asynchronous and active-low):

- `clk`  in  1  system clock. All logic is rising-edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `draw_valid`  in  1  rasterizer offers a pixel.
- `draw_ready`  out  1  scheduler accepts the offered pixel this cycle.
- `draw_x`  in  WIDTH_BITS  pixel x.
- `draw_y`  in  HEIGHT_BITS  pixel y.
- `draw_rgb`  in  3*CHANNEL_BITS  packed pixel colour {r,g,b}.
- `clear_req`  in  1  single-cycle pulse requesting a full-frame clear.
- `clear_rgb`  in  3*CHANNEL_BITS  clear colour, sampled in the cycle `clear_req`=1.
- `swap_req`  in  1  single-cycle pulse requesting a buffer swap.
- `data_ready_o`  out  1  write strobe to the memory controller's `data_ready_i`.
- `rdata`, `gdata`, `bdata`  out  CHANNEL_BITS each  pixel channels to the memory controller.
- `adddatax`  out  WIDTH_BITS  pixel x to the memory controller.
- `adddatay`  out  HEIGHT_BITS  pixel y to the memory controller.
- `flush`  out  1  one-cycle buffer-toggle pulse to the memory controller.
- `busy`  out  1  high when the state is not IDLE or any request is pending.
- `swap_done`  out  1  one-cycle pulse in the cycle after `flush`.

## Operation

- States: IDLE, DRAW, CLEAR, SWAP. All outputs are registered.
- Pending flags:
  - `clear_pend` is set by `clear_req`. Repeated requests coalesce; the latest `clear_rgb` wins while the clear is still pending.
  - `swap_pend` is set by `swap_req`. Repeated requests coalesce.
- `draw_ready` = (state ∈ {IDLE, DRAW}) & !clear_pend & !swap_pend. It is combinational from registers only.
- IDLE / DRAW:
  - The priority order is clear, then swap, then draw.
  - If `clear_pend`: go to CLEAR, clear `clear_pend`, latch the clear colour, zero the x/y counters.
  - Else if `swap_pend`: go to SWAP.
  - Else if `draw_valid & draw_ready`: go to DRAW and register x, y and rgb onto the outputs with `data_ready_o`=1.
  - Otherwise `data_ready_o`=0 and the state returns to IDLE.
- CLEAR:
  - Each cycle, output (cx, cy, clear colour) with `data_ready_o`=1.
  - Scan is row-major: cx increments; at cx=FRAME_W-1, cx wraps to 0 and cy increments.
  - After emitting (FRAME_W-1, FRAME_H-1), go to SWAP if `swap_pend`, else IDLE.
  - A `clear_req` arriving during CLEAR sets `clear_pend` and triggers another full clear afterwards; the current clear is not restarted.
- SWAP:
  - Lasts exactly one cycle, with `flush`=1 and `data_ready_o`=0. `swap_pend` is cleared.
  - Next state is IDLE. `swap_done`=1 in the following cycle.
- If `clear_req` and `swap_req` arrive together: the clear runs first, then the swap, so the cleared buffer is the one displayed.
- Counters are WIDTH_BITS / HEIGHT_BITS wide. Compare against FRAME_W-1 and FRAME_H-1; never rely on natural overflow.

## Timing

- Reset values:
  - state=IDLE.
  - `data_ready_o`, `flush`, `swap_done`, `busy` = 0.
  - `rdata`, `gdata`, `bdata`, `adddatax`, `adddatay` = 0.
  - pending flags and counters = 0.
- Reset asserted mid-clear or mid-swap aborts immediately; pending requests are discarded.
- Draw latency: a pixel accepted at edge N appears on the outputs with `data_ready_o`=1 during cycle N+1.
- Sustained draw throughput is one pixel per cycle.
- Clear duration: exactly FRAME_W*FRAME_H consecutive cycles with `data_ready_o`=1.
- A request pulse in cycle N is seen no earlier than edge N+1. `draw_ready` drops in cycle N+1.
- `flush` is never high in a cycle with `data_ready_o`=1. The write after a flush uses the new buffer.
- A draw beat with `draw_valid`=1 and `draw_ready`=0 must be held by the rasterizer; the scheduler drops nothing it has not accepted.

## Test plan

- Reset, then 3 consecutive draw beats (x=5,y=7,rgb=0xFF0000), (6,7,0x00FF00), (7,7,0x0000FF) -> outputs match one cycle later each, `data_ready_o`=1 for exactly 3 cycles, `flush` stays 0.
- FRAME_W=4, FRAME_H=3; `clear_req` with `clear_rgb`=0x123456 -> 12 consecutive writes (0,0)…(3,2) in row-major order, all 0x123456, then `busy`=0.
- `swap_req` alone -> `flush`=1 for exactly 1 cycle with `data_ready_o`=0, then `swap_done`=1 next cycle; two `swap_req` pulses 2 cycles apart while busy -> a single flush.
- `clear_req` and `swap_req` in the same cycle while `draw_valid` is held -> 12 clear writes, then the flush, then the held draw is accepted; `draw_ready`=0 throughout the clear and swap.
- `clear_req` during clear write #5 -> first clear completes, a second full 12-write clear follows, no gap longer than 1 cycle between the clears.
- Assert `n_rst` during clear write #6 -> all outputs are 0 immediately; after release, state=IDLE with no residual writes or flush.
